// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 constants: M-extension funct3 codes, mul/div FSM
//               state encoding and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// Module      : muldiv_datapath
// Description : Radix-2 shift-add multiply / restoring divide step on unsigned
//               magnitudes. acc = {high/remainder, low/quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [XLEN-1:0]     mag_a,
    input  logic [XLEN-1:0]     mag_b,
    output logic [2*XLEN-1:0]   acc
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_is_div;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shifted;
    logic [XLEN:0]     w_diff;

    always_comb begin
        w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_shifted = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = w_shifted - {1'b0, r_b};
    end

    // Both ops start with the first operand in the low half and zero above.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
        end else if (load) begin
            r_acc    <= {{XLEN{1'b0}}, mag_a};
            r_b      <= mag_b;
            r_is_div <= is_div;
        end else if (step) begin
            if (!r_is_div)
                r_acc <= {w_sum, r_acc[XLEN-1:1]};
            else if (!w_diff[XLEN])
                r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                r_acc <= {w_shifted[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/riscv_muldiv.sv
// ============================================================================
// Module      : riscv_muldiv
// Description : Iterative RV32 M-extension multiply/divide unit for the EX
//               stage; stalls the pipeline via busy and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic              r_special;
    logic [XLEN-1:0]   r_spec_val;
    logic [XLEN-1:0]   r_result;

    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
    logic              w_div_zero, w_ovf, w_load;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_val, w_fixed;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix;
    logic [2*XLEN-1:0] w_acc, w_prod_fix;

    always_comb begin
        w_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        w_b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_a_neg    = w_a_signed & op_a[XLEN-1];
        w_b_neg    = w_b_signed & op_b[XLEN-1];
        w_mag_a    = w_a_neg ? -op_a : op_a;
        w_mag_b    = w_b_neg ? -op_b : op_b;

        // Quotient/product sign is the XOR of operand signs; remainder follows the dividend.
        w_neg = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV:   w_neg = w_a_neg ^ w_b_neg;
            F3_MULHSU, F3_REM: w_neg = w_a_neg;
            default:           w_neg = 1'b0;
        endcase

        w_div_zero = funct3[2] && (op_b == '0);
        w_ovf      = funct3[2] && w_b_signed && (op_a == MIN_NEG) && (op_b == '1);
        w_spec_val = '0;
        if (w_div_zero)
            w_spec_val = funct3[1] ? op_a : '1;
        else if (w_ovf)
            w_spec_val = funct3[1] ? '0 : op_a;
    end

    assign w_load = (r_state == S_IDLE) && start && !flush;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .step   (r_state == S_CALC),
        .is_div (funct3[2]),
        .mag_a  (w_mag_a),
        .mag_b  (w_mag_b),
        .acc    (w_acc)
    );

    always_comb begin
        w_prod_fix = r_neg ? -w_acc : w_acc;
        w_quo_fix  = r_neg ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
        w_rem_fix  = r_neg ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];
        w_fixed    = '0;
        if (r_special)
            w_fixed = r_spec_val;
        else begin
            case (r_f3)
                F3_MUL:                       w_fixed = w_prod_fix[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: w_fixed = w_prod_fix[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              w_fixed = w_quo_fix;
                default:                      w_fixed = w_rem_fix;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_f3       <= '0;
            r_neg      <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_result   <= '0;
        end else if (flush && r_state != S_IDLE) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_f3       <= funct3;
                        r_neg      <= w_neg;
                        r_special  <= w_div_zero || w_ovf;
                        r_spec_val <= w_spec_val;
                        r_count    <= '0;
                        r_state    <= (w_div_zero || w_ovf) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(XLEN-1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fixed;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

`default_nettype wire

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
- Iterative multiply/divide unit for the EX stage of the 5-stage RV32 pipeline; implements the RISC-V M-extension ops.
- Parametrised in operand width (XLEN).
- While an op is in flight, `busy` stalls IF/ID/ID_EX, in the same way the hazard unit's `Stall` does.
- Result is returned to EX_MEM with a one-cycle `done` pulse.

Parameters:
- XLEN, 32, operand/result width in bits (even, ≥8).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 operand (forwarded value from EX).
- op_b  in  XLEN  rs2 operand.
- flush  in  1  abort in-flight op (branch/jump flush).
- busy  out  1  op in flight; pipeline stall request.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  result, held until next accepted start.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, all internal registers cleared. Reset in any state takes effect on the next edge and aborts the op; no `done` is produced.
- Clock and reset are a single clk domain with a synchronous, active-high reset (`reset`).
- States: IDLE, CALC, FIX, DONE.
  - IDLE: start=1 latches funct3, op_a, op_b. Magnitudes are computed for signed ops: MULH uses both operands, MULHSU uses op_a only, DIV/REM use both. Next state is CALC with count=0, or FIX if a special case applies.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*XLEN product register.
    - Divide: restoring shift-subtract; quotient and remainder registers are XLEN each.
    - count increments; after XLEN steps go to FIX.
  - FIX: apply sign correction and select the output word.
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits of the signed-corrected 2*XLEN product.
    - DIV sign: quotient negated if signs differ. REM sign: remainder takes the dividend's sign.
    - Register `result`, go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- busy=1 in CALC, FIX and DONE; 0 in IDLE. busy rises the cycle after start is accepted.
- Latency, normal path: done is high exactly XLEN+2 cycles after the start cycle (34 cycles at XLEN=32).
- Special cases bypass CALC; done is high 2 cycles after start.
  - Divide by zero (op_b==0): DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (DIV/REM with op_a = most negative value and op_b = all ones): quotient = op_a; remainder = 0.
- start while busy: ignored; no queuing.
- flush: in any non-IDLE state, go to IDLE on the next edge with busy=0. done is not asserted and result is unchanged.
  - If flush is high in DONE, done is already high that cycle and is still delivered.
  - If flush and start arrive together in IDLE, flush wins and the request is dropped.
- All arithmetic is unsigned on magnitudes. Negation is two's complement at XLEN or 2*XLEN width; wrap-around is discarded.

Decomposition:
- Shared package `riscv_pkg` holds:
  - M-extension funct3 localparams (F3_MUL … F3_REMU).
  - State encoding enum.
  - XLEN default constant shared with the existing ALU.
- One natural sub-module: `muldiv_datapath`. It holds the product/quotient/remainder registers and the shift-add / shift-sub step. The FSM, special-case detection and sign fix stay in `riscv_muldiv`.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD → result 0xFFFFFFEB. done pulse at cycle 34 after start; busy high cycles 1–34.
2. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both with done at cycle 2. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, done at cycle 2.
5. Flush at cycle 10 of a DIV → busy=0 at cycle 11, no done, result unchanged. A new start at cycle 12 completes normally at cycle 46. A start pulsed at cycle 5 of an op is ignored.
6. Reset asserted mid-CALC → next cycle busy=0, done=0, result=0. Sweep of random operands, all 8 ops, against a reference model at XLEN=32 and XLEN=16.
